pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
Consumes the main PLL's asynchronous `locked` output and drives the PLL's `rst` input. It produces staged, ordered reset releases for the NUM_DOMAINS design domains fed by the PLL outputs. It runs on the free-running board reference clock, not on a PLL output, so it keeps working while the PLL is unlocked. On a lock timeout it retries the PLL reset; on loss of lock it re-asserts every domain reset. Per-domain resynchronisation into each outclk domain is out of scope.

Parameters:
PLL_RST_CYCLES, 16, cycles pll_rst is held high per attempt (>=1)
LOCK_TIMEOUT_CYCLES, 65536, cycles to wait for lock before retrying the PLL reset (>=1)
LOCK_STABLE_CYCLES, 1024, cycles locked must stay continuously high before any release (>=1)
STAGE_GAP_CYCLES, 8, cycles between successive domain releases (>=1)
NUM_DOMAINS, 4, number of staged domain resets (1..8)

Ports:
clk  in  1  free-running reference clock, same source as the PLL refclk
rst  in  1  synchronous active-high reset
pll_locked  in  1  PLL locked, asynchronous to clk
pll_rst  out  1  drives the PLL rst input, active-high
dom_rst  out  NUM_DOMAINS  per-domain resets, active-high, index 0 released first
all_ready  out  1  high when every domain is released and the FSM is in S_RUN
lock_lost  out  1  one-cycle pulse on loss of lock after release began
state  out  3  current FSM state, for debug

Behaviour:
- The clock is `clk`. Reset is `rst`, synchronous and active-high.
- While rst is high and on the edge it is sampled:
  - state=S_PLLRST, pll_rst=1, dom_rst=all ones, all_ready=0, lock_lost=0.
  - Counter cnt=0, stage index idx=0, synchroniser flops=0.
- Synchronisation: pll_locked passes through a 2-flop synchroniser to give locked_s. Edges E0/E1 are the edges where flop1/flop2 first capture 1.
- All outputs are registered. cnt is 17 bits or wider, sized by $clog2 of the largest parameter.
- S_PLLRST (0):
  - pll_rst=1.
  - At cnt==PLL_RST_CYCLES-1: go to S_WAIT, cnt=0, pll_rst=0.
  - pll_rst is therefore high for exactly PLL_RST_CYCLES cycles after rst falls.
- S_WAIT (1):
  - If locked_s: go to S_STABLE, cnt=0.
  - Else if cnt==LOCK_TIMEOUT_CYCLES-1: go to S_PLLRST, cnt=0.
  - Else cnt++.
- S_STABLE (2):
  - If !locked_s: go to S_WAIT, cnt=0 (timeout restarts). No lock_lost pulse.
  - Else if cnt==LOCK_STABLE_CYCLES-1: go to S_RELEASE, cnt=0, idx=0.
  - Else cnt++.
- S_RELEASE (3):
  - At cnt==STAGE_GAP_CYCLES-1: clear dom_rst[idx], idx++, cnt=0.
  - On the edge that clears dom_rst[NUM_DOMAINS-1], also go to S_RUN with all_ready=1.
- S_RUN (4): hold. all_ready=1.
- Release timing: with FSM entry to S_STABLE at E2, dom_rst[k] falls after edge E2+LOCK_STABLE_CYCLES+(k+1)*STAGE_GAP_CYCLES.
- Lock loss: locked_s low in S_RELEASE or S_RUN. On the next edge:
  - lock_lost=1 for one cycle.
  - dom_rst=all ones, all_ready=0.
  - Go to S_PLLRST with cnt=0 and pll_rst=1.
- Domain release order is strictly ascending. Released domains never re-assert individually.
- rst asserted mid-sequence overrides everything and gives the reset values on that edge.
- pll_locked glitches shorter than one clk period may be missed. This is acceptable.
- Unused state encodes (5..7) recover to S_PLLRST on the next edge.

Optional Feature:
PLL_RST_LOSS_COUNT_EN
- Defined: adds output loss_cnt, 8 bits.
  - Saturating at 255.
  - Increments on each lock_lost pulse and on each S_WAIT timeout.
  - Cleared only by rst.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package pll_rst_pkg:
  - State enum: S_PLLRST=0, S_WAIT=1, S_STABLE=2, S_RELEASE=3, S_RUN=4.
  - STATE_W=3.
  - Function computing the counter width from the parameters.
- One sub-module, rst_sync_2ff: a generic 2-flop synchroniser with synchronous reset to 0, used for pll_locked.

Test Plan:
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=4, STAGE_GAP_CYCLES=2, NUM_DOMAINS=4.
1. Reset, then release rst -> pll_rst high exactly 4 cycles, then low. dom_rst=4'b1111, all_ready=0 throughout.
2. Raise pll_locked 3 cycles after pll_rst falls and hold it -> dom_rst falls to 1110, 1100, 1000, 0000 at E2+6, E2+8, E2+10, E2+12. all_ready=1 on the same edge as 0000.
3. Never raise pll_locked -> pll_rst re-pulses (4 cycles) every 24 cycles. dom_rst stays all ones. With macro, loss_cnt increments per timeout.
4. In S_STABLE, drop pll_locked for 2 cycles at cnt=2 -> returns to S_WAIT with no release and no lock_lost. Re-lock restarts the full 4-cycle stability count.
5. In S_RUN, drop pll_locked -> lock_lost pulses 1 cycle, dom_rst=1111, all_ready=0 on that same edge. pll_rst=1 for 4 cycles. The full sequence then repeats on re-lock.
6. Assert rst mid-S_RELEASE with dom_rst=1100 -> on that edge dom_rst=1111, state=0, pll_rst=1. Macro loss_cnt saturates at 255 after 300 forced losses.

Source files
------------

// File: rtl/pll_rst_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_rst_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_PLLRST  = 3'd0,
    S_WAIT    = 3'd1,
    S_STABLE  = 3'd2,
    S_RELEASE = 3'd3,
    S_RUN     = 3'd4
  } state_e;

  // Counter width covers the largest timing parameter, never narrower than 17 bits.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    w = $clog2(m + 1);
    return (w < 17) ? 17 : w;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-side and domain-side signals of the reset sequencer.
// PLL_RST_LOSS_COUNT_EN adds the saturating loss_cnt output.
interface pll_reset_sequencer_if
  import pll_rst_pkg::*;
#(
  parameter int NUM_DOMAINS = 4
);
  logic                   pll_locked;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] dom_rst;
  logic                   all_ready;
  logic                   lock_lost;
  logic [STATE_W-1:0]     state;
`ifdef PLL_RST_LOSS_COUNT_EN
  logic [7:0]             loss_cnt;

  modport master (
    input  pll_locked,
    output pll_rst, dom_rst, all_ready, lock_lost, state, loss_cnt
  );

  modport slave (
    output pll_locked,
    input  pll_rst, dom_rst, all_ready, lock_lost, state, loss_cnt
  );
`else
  modport master (
    input  pll_locked,
    output pll_rst, dom_rst, all_ready, lock_lost, state
  );

  modport slave (
    output pll_locked,
    input  pll_rst, dom_rst, all_ready, lock_lost, state
  );
`endif
endinterface

// File: rtl/rst_sync_2ff.sv
// Generic two-flop synchroniser with synchronous clear to 0.
module rst_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock-qualification sequencer with staged domain releases.
// PLL_RST_LOSS_COUNT_EN adds a saturating count of lock losses and lock timeouts.
//
// state     | meaning
// ----------+-------------------------------------------------------
// S_PLLRST  | pll_rst held high for PLL_RST_CYCLES
// S_WAIT    | waiting for lock, retry after LOCK_TIMEOUT_CYCLES
// S_STABLE  | lock must hold for LOCK_STABLE_CYCLES
// S_RELEASE | releasing dom_rst[idx] every STAGE_GAP_CYCLES
// S_RUN     | all domains released, watching for lock loss
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int STAGE_GAP_CYCLES    = 8,
  parameter int NUM_DOMAINS         = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pll_reset_sequencer_if.master bus
);
  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                   LOCK_STABLE_CYCLES, STAGE_GAP_CYCLES);
  localparam int IDX_W = $clog2(NUM_DOMAINS + 1);

  localparam logic [STATE_W-1:0] ST_PLLRST  = S_PLLRST;
  localparam logic [STATE_W-1:0] ST_WAIT    = S_WAIT;
  localparam logic [STATE_W-1:0] ST_STABLE  = S_STABLE;
  localparam logic [STATE_W-1:0] ST_RELEASE = S_RELEASE;
  localparam logic [STATE_W-1:0] ST_RUN     = S_RUN;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);

  logic                   locked_s;
  logic [STATE_W-1:0]     state_q, state_nxt;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0]       idx, idx_nxt;
  logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_nxt;
  logic                   pll_rst_q, all_ready_q, lock_lost_q;
  logic                   lose, timeout;

  rst_sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (locked_s)
  );

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    dom_rst_nxt = dom_rst_q;
    lose        = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      ST_PLLRST: begin
        if (cnt == PLL_RST_LAST) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_WAIT: begin
        if (locked_s) begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nxt = ST_PLLRST;
          cnt_nxt   = '0;
          timeout   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_STABLE: begin
        // A dropout before release only restarts the wait, it is not a loss.
        if (!locked_s) begin
          state_nxt = ST_WAIT;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = ST_RELEASE;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!locked_s) begin
          lose = 1'b1;
        end else if (cnt == GAP_LAST) begin
          for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (idx == IDX_W'(k)) dom_rst_nxt[k] = 1'b0;
          end
          idx_nxt = idx + 1'b1;
          cnt_nxt = '0;
          if (idx == IDX_LAST) state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (!locked_s) lose = 1'b1;
      end
      default: begin
        state_nxt   = ST_PLLRST;
        cnt_nxt     = '0;
        idx_nxt     = '0;
        dom_rst_nxt = '1;
      end
    endcase
    if (lose) begin
      state_nxt   = ST_PLLRST;
      cnt_nxt     = '0;
      idx_nxt     = '0;
      dom_rst_nxt = '1;
    end
  end

  // Flag outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PLLRST;
      cnt         <= '0;
      idx         <= '0;
      dom_rst_q   <= '1;
      pll_rst_q   <= 1'b1;
      all_ready_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      dom_rst_q   <= dom_rst_nxt;
      pll_rst_q   <= (state_nxt == ST_PLLRST);
      all_ready_q <= (state_nxt == ST_RUN);
      lock_lost_q <= lose;
    end
  end

`ifdef PLL_RST_LOSS_COUNT_EN
  logic [7:0] loss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      loss_cnt_q <= '0;
    end else if ((lose || timeout) && (loss_cnt_q != 8'hFF)) begin
      loss_cnt_q <= loss_cnt_q + 8'd1;
    end
  end

  assign bus.loss_cnt = loss_cnt_q;
`else
  logic unused_timeout;
  assign unused_timeout = timeout;
`endif

  assign bus.pll_rst   = pll_rst_q;
  assign bus.dom_rst   = dom_rst_q;
  assign bus.all_ready = all_ready_q;
  assign bus.lock_lost = lock_lost_q;
  assign bus.state     = state_q;

endmodule
